alu_result_commit: RTL and testbench

//  Stage directly downstream of the ALU: captures ALU result, flags and destination,

---
 rtl/alu_pkg.sv | 36 +++
 rtl/mem_port_fsm.sv | 85 ++++++++
 rtl/alu_result_commit.sv | 183 ++++++++++++++++++
 tb/tb_alu_result_commit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result/commit stage: opcode constants,
// commit state encoding, NZCV flag layout and opcode classification helpers.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned NZCV_W = 4;

    localparam logic [OP_W-1:0] OP_CMP = 4'b1011;
    localparam logic [OP_W-1:0] OP_LDR = 4'b1101;
    localparam logic [OP_W-1:0] OP_STR = 4'b1110;

    // Commit stage states: idle, memory request outstanding, writeback cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } commit_state_t;

    // Architectural flag register, N in bit 3 down to V in bit 0.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Opcodes 0000-0111 are register-writing ALU operations.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ~op[OP_W-1];
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Memory request port: holds mem_req with stable address/data from start until
// an ack or timeout, counts cycles waiting, and keeps the sticky error flag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_start             launch a request (only while idle)
//   i_we/i_addr/i_wdata request payload captured on i_start
//   i_ack               single-cycle completion strobe from memory
//   o_req/o_we/o_addr/o_wdata  registered memory request outputs
//   o_err               sticky timeout flag
//   o_done_c            ack seen while request outstanding (combinational)
//   o_timeout_c         request expires this cycle without ack (combinational)
module mem_port_fsm
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    output logic              o_req,
    output logic              o_we,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_err,
    output logic              o_done_c,
    output logic              o_timeout_c
);

    localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    // Ack in the final waiting cycle takes priority over expiry.
    assign o_done_c    = r_req & i_ack;
    assign o_timeout_c = r_req & ~i_ack & (r_cnt == CNT_LAST);

    // Request hold and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_req   <= 1'b1;
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_we ? i_wdata : '0;
            r_cnt   <= '0;
        end else if (o_done_c || o_timeout_c) begin
            r_req <= 1'b0;
            r_cnt <= '0;
        end else if (r_req) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (o_timeout_c) begin
            r_err <= 1'b1;
        end
    end

    assign o_req   = r_req;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_err   = r_err;

endmodule

// File: rtl/alu_result_commit.sv
// ALU result commit stage: captures an executed instruction, updates the NZCV
// flag register, performs ldr/str through the memory port, and issues a single
// register-file write strobe. One instruction in flight; ex_ready only in IDLE.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ex_*                            instruction from execute stage, ex_ready back
//   mem_req/we/addr/wdata, mem_ack/rdata   memory request port
//   wb_we/wb_addr/wb_data           register-file write port
//   flags_q                         architectural NZCV
//   mem_err                         sticky memory timeout
module alu_result_commit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic              ex_cond_met,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [NZCV_W-1:0] ex_flags,
    input  logic              ex_flag_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [NZCV_W-1:0] flags_q,
    output logic              mem_err
);

    commit_state_t     r_state;
    commit_state_t     w_state_nxt;
    logic              r_ex_ready;
    logic              r_wb_we;
    logic [REG_AW-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [REG_AW-1:0] r_rd;
    nzcv_t             r_flags;

    logic              w_accept;
    logic              w_issue;
    logic              w_mem_start_c;
    logic              w_mem_we;
    logic              w_mem_done_c;
    logic              w_mem_timeout_c;
    logic              w_wb_we_nxt;
    logic [REG_AW-1:0] w_wb_addr_nxt;
    logic [DATA_W-1:0] w_wb_data_nxt;
    logic [REG_AW-1:0] w_rd_nxt;
    nzcv_t             w_flags_nxt;

    assign w_accept = ex_valid & r_ex_ready;
    assign w_issue  = w_accept & ex_cond_met;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; squashed, cmp and unused opcodes stay in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (is_mem_op(ex_opcode)) begin
                        w_state_nxt = MEM;
                    end else if (is_alu_op(ex_opcode)) begin
                        w_state_nxt = WB;
                    end
                end
            end
            MEM: begin
                if (w_mem_done_c) begin
                    w_state_nxt = w_mem_we ? IDLE : WB;
                end else if (w_mem_timeout_c) begin
                    w_state_nxt = IDLE;
                end
            end
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and capture regs.
    always_comb begin
        w_wb_we_nxt   = 1'b0;
        w_wb_addr_nxt = r_wb_addr;
        w_wb_data_nxt = r_wb_data;
        w_rd_nxt      = r_rd;
        w_flags_nxt   = r_flags;
        w_mem_start_c = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (ex_flag_we) begin
                        w_flags_nxt = nzcv_t'(ex_flags);
                    end
                    if (is_alu_op(ex_opcode)) begin
                        w_wb_we_nxt   = 1'b1;
                        w_wb_addr_nxt = ex_rd;
                        w_wb_data_nxt = ex_result;
                    end
                    if (is_mem_op(ex_opcode)) begin
                        w_mem_start_c = 1'b1;
                        w_rd_nxt      = ex_rd;
                    end
                end
            end
            MEM: begin
                // Load data is only valid alongside the ack strobe.
                if (w_mem_done_c && !w_mem_we) begin
                    w_wb_we_nxt   = 1'b1;
                    w_wb_addr_nxt = r_rd;
                    w_wb_data_nxt = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and captured destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ready <= 1'b1;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_rd       <= '0;
            r_flags    <= '0;
        end else begin
            r_ex_ready <= (w_state_nxt == IDLE);
            r_wb_we    <= w_wb_we_nxt;
            r_wb_addr  <= w_wb_addr_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_rd       <= w_rd_nxt;
            r_flags    <= w_flags_nxt;
        end
    end

    mem_port_fsm #(
        .DATA_W      (DATA_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_mem_start_c),
        .i_we        (ex_opcode == OP_STR),
        .i_addr      (ex_result),
        .i_wdata     (ex_store_data),
        .i_ack       (mem_ack),
        .o_req       (mem_req),
        .o_we        (w_mem_we),
        .o_addr      (mem_addr),
        .o_wdata     (mem_wdata),
        .o_err       (mem_err),
        .o_done_c    (w_mem_done_c),
        .o_timeout_c (w_mem_timeout_c)
    );

    assign mem_we   = w_mem_we;
    assign ex_ready = r_ex_ready;
    assign wb_we    = r_wb_we;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign flags_q  = r_flags;

endmodule

// File: tb/tb_alu_result_commit.sv
// Bench for alu_result_commit: directed scenarios plus a randomized run checked
// against a per-instruction behavioural model (flags, sticky error, expected
// writeback and memory-request duration).
module tb_alu_result_commit;
    import alu_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned TMO = 4;

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_opcode;
    logic          ex_cond_met;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] ex_store_data;
    logic [AW-1:0] ex_rd;
    logic [3:0]    ex_flags;
    logic          ex_flag_we;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    flags_q;
    logic          mem_err;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: architectural flags and sticky error.
    logic [3:0] m_flags;
    logic       m_err;

    alu_result_commit #(
        .DATA_W      (DW),
        .REG_AW      (AW),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_cond_met   (ex_cond_met),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_flags      (ex_flags),
        .ex_flag_we    (ex_flag_we),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .flags_q       (flags_q),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-valid cycles carry garbage so the DUT must sample only on accept.
    task automatic scramble();
        ex_opcode     = 4'($urandom);
        ex_cond_met   = 1'($urandom);
        ex_result     = $urandom;
        ex_store_data = $urandom;
        ex_rd         = 4'($urandom);
        ex_flags      = 4'($urandom);
        ex_flag_we    = 1'($urandom);
        mem_rdata     = $urandom;
    endtask

    // Present one instruction at a negedge, hold it across one rising edge.
    task automatic send(input logic [3:0] op, input logic cm, input logic [DW-1:0] res,
                        input logic [DW-1:0] sd, input logic [AW-1:0] rd,
                        input logic [3:0] fl, input logic fwe);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_cond_met   = cm;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_flags      = fl;
        ex_flag_we    = fwe;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        scramble();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        mem_ack  = 1'b0;
        scramble();
        m_flags = 4'h0;
        m_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_we, wb_addr, wb_data, flags_q, mem_err} !== '0)
            $display("FAIL reset_outputs got=%h expected=0",
                     {mem_req, mem_we, mem_addr, mem_wdata, wb_we, wb_addr, wb_data, flags_q, mem_err});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({ex_ready, mem_req, wb_we} !== 3'b100)
            $display("FAIL reset_release ready/req/wb got=%b expected=100", {ex_ready, mem_req, wb_we});
        else n_pass++;
    endtask

    task automatic test_alu_op();
        send(4'b0000, 1'b1, 32'h0000_0005, 32'h0, 4'd3, 4'h0, 1'b0);
        @(negedge clk);
        n_total++;
        if ({wb_we, wb_addr, wb_data, ex_ready} !== {1'b1, 4'd3, 32'd5, 1'b0})
            $display("FAIL alu_wb we/addr/data/ready got=%h expected=%h",
                     {wb_we, wb_addr, wb_data, ex_ready}, {1'b1, 4'd3, 32'd5, 1'b0});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({wb_we, ex_ready} !== 2'b01)
            $display("FAIL alu_wb_one_cycle we/ready got=%b expected=01", {wb_we, ex_ready});
        else n_pass++;
    endtask

    task automatic test_cmp();
        send(OP_CMP, 1'b1, 32'h1234, 32'h0, 4'd9, 4'b0100, 1'b1);
        m_flags = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if ({wb_we, flags_q, ex_ready} !== {1'b0, m_flags, 1'b1})
                $display("FAIL cmp_flags cycle%0d we/flags/ready got=%h expected=%h",
                         k, {wb_we, flags_q, ex_ready}, {1'b0, m_flags, 1'b1});
            else n_pass++;
        end
    endtask

    // ldr with ack in cycle 'dly' of the request (dly == TMO exercises the tie).
    task automatic test_ldr(input int dly, input logic [DW-1:0] addr, input logic [DW-1:0] rdat);
        send(OP_LDR, 1'b1, addr, 32'hFFFF_FFFF, 4'd7, 4'h0, 1'b0);
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            n_total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, ex_ready} !== {1'b1, 1'b0, addr, 32'h0, 1'b0})
                $display("FAIL ldr_req cycle%0d req/we/addr/wdata/ready got=%h expected=%h",
                         k, {mem_req, mem_we, mem_addr, mem_wdata, ex_ready},
                         {1'b1, 1'b0, addr, 32'h0, 1'b0});
            else n_pass++;
            if (k == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rdat;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        n_total++;
        if ({mem_req, wb_we, wb_addr, wb_data, ex_ready, mem_err} !== {1'b0, 1'b1, 4'd7, rdat, 1'b0, m_err})
            $display("FAIL ldr_wb req/we/addr/data/ready/err got=%h expected=%h",
                     {mem_req, wb_we, wb_addr, wb_data, ex_ready, mem_err},
                     {1'b0, 1'b1, 4'd7, rdat, 1'b0, m_err});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({wb_we, ex_ready} !== 2'b01)
            $display("FAIL ldr_wb_end we/ready got=%b expected=01", {wb_we, ex_ready});
        else n_pass++;
    endtask

    task automatic test_str();
        send(OP_STR, 1'b1, 32'h40, 32'h1234, 4'd2, 4'h0, 1'b0);
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, ex_ready} !== {1'b1, 1'b1, 32'h40, 32'h1234, 1'b0})
            $display("FAIL str_req req/we/addr/wdata/ready got=%h expected=%h",
                     {mem_req, mem_we, mem_addr, mem_wdata, ex_ready},
                     {1'b1, 1'b1, 32'h40, 32'h1234, 1'b0});
        else n_pass++;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_total++;
        if ({mem_req, wb_we, ex_ready, mem_err} !== {1'b0, 1'b0, 1'b1, m_err})
            $display("FAIL str_done req/we/ready/err got=%b expected=%b",
                     {mem_req, wb_we, ex_ready, mem_err}, {1'b0, 1'b0, 1'b1, m_err});
        else n_pass++;
    endtask

    task automatic test_timeout();
        send(OP_LDR, 1'b1, 32'h200, 32'h0, 4'd5, 4'h0, 1'b0);
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            n_total++;
            if ({mem_req, mem_err, wb_we} !== 3'b100)
                $display("FAIL timeout_wait cycle%0d req/err/we got=%b expected=100",
                         k, {mem_req, mem_err, wb_we});
            else n_pass++;
        end
        m_err = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, mem_err, wb_we, ex_ready} !== 4'b0101)
            $display("FAIL timeout_abort req/err/we/ready got=%b expected=0101",
                     {mem_req, mem_err, wb_we, ex_ready});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({wb_we, mem_err} !== 2'b01)
            $display("FAIL timeout_sticky we/err got=%b expected=01", {wb_we, mem_err});
        else n_pass++;
    endtask

    task automatic test_squash();
        send(4'b0010, 1'b0, 32'hAAAA, 32'h0, 4'd4, ~m_flags, 1'b1);
        @(negedge clk);
        n_total++;
        if ({wb_we, flags_q, ex_ready, mem_req} !== {1'b0, m_flags, 1'b1, 1'b0})
            $display("FAIL squash_alu we/flags/ready/req got=%h expected=%h",
                     {wb_we, flags_q, ex_ready, mem_req}, {1'b0, m_flags, 1'b1, 1'b0});
        else n_pass++;
        send(OP_LDR, 1'b0, 32'h300, 32'h0, 4'd4, 4'h0, 1'b0);
        @(negedge clk);
        n_total++;
        if ({mem_req, wb_we, ex_ready} !== 3'b001)
            $display("FAIL squash_ldr req/we/ready got=%b expected=001", {mem_req, wb_we, ex_ready});
        else n_pass++;
        // Stray ack while idle must be ignored.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_req, wb_we, ex_ready, mem_err} !== {1'b0, 1'b0, 1'b1, m_err})
            $display("FAIL stray_ack req/we/ready/err got=%b expected=%b",
                     {mem_req, wb_we, ex_ready, mem_err}, {1'b0, 1'b0, 1'b1, m_err});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]    op;
        logic          cm;
        logic [DW-1:0] res;
        logic [DW-1:0] sd;
        logic [AW-1:0] rd;
        logic [3:0]    fl;
        logic          fwe;
        logic [DW-1:0] rdat;
        logic          is_st;
        logic          exp_wb;
        int            dly;
        int            nreq;
        for (int i = 0; i < 60; i++) begin
            op   = 4'($urandom_range(15));
            if ($urandom_range(2) == 0) op = ($urandom_range(1) == 1) ? OP_LDR : OP_STR;
            cm   = ($urandom_range(3) != 0);
            res  = $urandom;
            sd   = $urandom;
            rd   = 4'($urandom);
            fl   = 4'($urandom);
            fwe  = 1'($urandom);
            rdat = $urandom;
            dly  = $urandom_range(1, 6);
            is_st = (op == OP_STR);
            if ($urandom_range(3) == 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                n_total++;
                if ({mem_req, wb_we, ex_ready} !== 3'b001)
                    $display("FAIL rnd%0d idle_ack req/we/ready got=%b expected=001",
                             i, {mem_req, wb_we, ex_ready});
                else n_pass++;
            end
            send(op, cm, res, sd, rd, fl, fwe);
            if (cm && fwe) m_flags = fl;
            if (cm && (op == OP_LDR || op == OP_STR)) begin
                nreq = (dly <= int'(TMO)) ? dly : int'(TMO);
                for (int k = 1; k <= nreq; k++) begin
                    @(negedge clk);
                    mem_ack = 1'b0;
                    n_total++;
                    if ({mem_req, mem_we, mem_addr, mem_wdata, ex_ready, flags_q} !==
                        {1'b1, is_st, res, is_st ? sd : 32'h0, 1'b0, m_flags})
                        $display("FAIL rnd%0d mem_cycle%0d got=%h expected=%h", i, k,
                                 {mem_req, mem_we, mem_addr, mem_wdata, ex_ready, flags_q},
                                 {1'b1, is_st, res, is_st ? sd : 32'h0, 1'b0, m_flags});
                    else n_pass++;
                    if (k == dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rdat;
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
                if (dly > int'(TMO)) m_err = 1'b1;
                exp_wb = !is_st && (dly <= int'(TMO));
                n_total++;
                if ({mem_req, wb_we, mem_err, ex_ready} !== {1'b0, exp_wb, m_err, !exp_wb})
                    $display("FAIL rnd%0d mem_exit req/we/err/ready got=%b expected=%b", i,
                             {mem_req, wb_we, mem_err, ex_ready}, {1'b0, exp_wb, m_err, !exp_wb});
                else n_pass++;
                if (exp_wb) begin
                    n_total++;
                    if ({wb_addr, wb_data} !== {rd, rdat})
                        $display("FAIL rnd%0d ldr_data addr/data got=%h expected=%h",
                                 i, {wb_addr, wb_data}, {rd, rdat});
                    else n_pass++;
                    @(negedge clk);
                end
            end else if (cm && op[3] == 1'b0) begin
                @(negedge clk);
                n_total++;
                if ({wb_we, wb_addr, wb_data, ex_ready, flags_q} !== {1'b1, rd, res, 1'b0, m_flags})
                    $display("FAIL rnd%0d alu_wb got=%h expected=%h", i,
                             {wb_we, wb_addr, wb_data, ex_ready, flags_q},
                             {1'b1, rd, res, 1'b0, m_flags});
                else n_pass++;
                @(negedge clk);
            end else begin
                @(negedge clk);
                n_total++;
                if ({wb_we, mem_req, ex_ready, flags_q} !== {1'b0, 1'b0, 1'b1, m_flags})
                    $display("FAIL rnd%0d noop we/req/ready/flags got=%h expected=%h", i,
                             {wb_we, mem_req, ex_ready, flags_q}, {1'b0, 1'b0, 1'b1, m_flags});
                else n_pass++;
            end
            n_total++;
            if ({wb_we, ex_ready} !== 2'b01)
                $display("FAIL rnd%0d settle we/ready got=%b expected=01", i, {wb_we, ex_ready});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mem();
        send(OP_STR, 1'b1, 32'h500, 32'h77, 4'd1, 4'hF, 1'b1);
        @(negedge clk);
        n_total++;
        if (mem_req !== 1'b1)
            $display("FAIL rst_mid_pre req got=%b expected=1", mem_req);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        m_flags = 4'h0;
        m_err   = 1'b0;
        n_total++;
        if ({mem_req, mem_we, wb_we, flags_q, mem_err} !== 8'h00)
            $display("FAIL rst_mid_drop req/we/wb/flags/err got=%b expected=0",
                     {mem_req, mem_we, wb_we, flags_q, mem_err});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({ex_ready, mem_req, wb_we} !== 3'b100)
            $display("FAIL rst_mid_release ready/req/we got=%b expected=100", {ex_ready, mem_req, wb_we});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_cmp();
        test_ldr(3, 32'h100, 32'hDEAD_BEEF);
        test_str();
        test_ldr(int'(TMO), 32'h180, 32'hCAFE_F00D);
        test_squash();
        test_timeout();
        test_random();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
